// File: rtl/speck_pkg.sv
// Purpose: shared widths, round constants, FSM encoding and rotate helpers for the SPECK32/64 sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package speck_pkg;

    localparam int WORD   = 16;
    localparam int ROUNDS = 22;
    localparam int ALPHA  = 7;
    localparam int BETA   = 2;
    localparam int IDX_W  = 5;

    typedef logic [WORD-1:0]  word_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam idx_t LAST_ROUND = idx_t'(ROUNDS - 1);

    function automatic word_t ror(input word_t v, input int unsigned n);
        return (v >> n) | (v << (WORD - n));
    endfunction

    function automatic word_t rol(input word_t v, input int unsigned n);
        return (v << n) | (v >> (WORD - n));
    endfunction

endpackage

// File: rtl/speck_round.sv
// Purpose: one SPECK round, x' = (ROR(x,ALPHA)+y)^k, y' = ROL(y,BETA)^x'.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: x, y, k in (WORD each); x_nxt, y_nxt out (WORD each).
module speck_round
    import speck_pkg::*;
(
    input  logic [WORD-1:0] x,
    input  logic [WORD-1:0] y,
    input  logic [WORD-1:0] k,
    output logic [WORD-1:0] x_nxt,
    output logic [WORD-1:0] y_nxt
);

    word_t sum;

    // Addition is mod 2^WORD; the carry out simply falls off the top.
    assign sum   = ror(x, ALPHA) + y;
    assign x_nxt = sum ^ k;
    assign y_nxt = rol(y, BETA) ^ x_nxt;

endmodule

// File: rtl/speck_iter_ctrl.sv
// Purpose: iterative SPECK32/64 encryptor, one round per clock, key schedule expanded on the fly.
// Latency: out_valid first visible 23 cycles after the accept cycle (22 rounds + output stage).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, one block per 24 cycles max.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_block/in_key input handshake;
//        out_valid/out_ready/left/right result handshake; busy, round_idx, debug_key status.
module speck_iter_ctrl
    import speck_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*WORD-1:0] in_block,
    input  logic [4*WORD-1:0] in_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD-1:0]   left,
    output logic [WORD-1:0]   right,
    output logic              busy,
    output logic [IDX_W-1:0]  round_idx,
    output logic [WORD-1:0]   debug_key
);

    state_t state, state_nxt;
    logic   accept;
    logic   last_round;

    // Working state: data halves, current round key and the three pending l words (l0 = l_i).
    word_t x, y, k, l0, l1, l2;
    word_t x_nxt, y_nxt, l_new, k_nxt;
    word_t idx_word;

    assign idx_word = {{(WORD-IDX_W){1'b0}}, round_idx};

    speck_round u_data (
        .x     (x),
        .y     (y),
        .k     (k),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt)
    );

    // The key schedule is the same round function, with l_i as x, k_i as y and the round index as key.
    speck_round u_key (
        .x     (l0),
        .y     (k),
        .k     (idx_word),
        .x_nxt (l_new),
        .y_nxt (k_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        last_round = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        debug_key  = '0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy      = 1'b1;
                debug_key = k;
                if (round_idx == LAST_ROUND) begin
                    last_round = 1'b1;
                    state_nxt  = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            k         <= '0;
            l0        <= '0;
            l1        <= '0;
            l2        <= '0;
            round_idx <= '0;
            left      <= '0;
            right     <= '0;
        end else if (accept) begin
            x         <= in_block[2*WORD-1:WORD];
            y         <= in_block[WORD-1:0];
            k         <= in_key[WORD-1:0];
            l0        <= in_key[2*WORD-1:WORD];
            l1        <= in_key[3*WORD-1:2*WORD];
            l2        <= in_key[4*WORD-1:3*WORD];
            round_idx <= '0;
        end else if (state == RUN) begin
            x  <= x_nxt;
            y  <= y_nxt;
            k  <= k_nxt;
            l0 <= l1;
            l1 <= l2;
            l2 <= l_new;
            if (last_round) begin
                // Ciphertext lands in the output registers; the counter is parked at 0 for DONE/IDLE.
                left      <= x_nxt;
                right     <= y_nxt;
                round_idx <= '0;
            end else begin
                round_idx <= round_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_speck_iter_ctrl.sv
module tb_speck_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_block;
    logic [63:0] in_key;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] left;
    logic [15:0] right;
    logic        busy;
    logic [4:0]  round_idx;
    logic [15:0] debug_key;

    int errors = 0;
    int checks = 0;

    int unsigned mk [0:21];

    logic [31:0] exp_q [$];

    localparam logic [63:0] KAT_KEY = 64'h1918111009080100;
    localparam logic [31:0] KAT_BLK = 32'h6574694C;
    localparam logic [31:0] KAT_CT  = 32'hA86842F2;

    speck_iter_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .left      (left),
        .right     (right),
        .busy      (busy),
        .round_idx (round_idx),
        .debug_key (debug_key)
    );

    always #5 clk = ~clk;

    // Software SPECK32/64: textbook form with the l sequence held as an array.
    function automatic int unsigned ror16(input int unsigned v, input int unsigned n);
        return ((v >> n) | (v << (16 - n))) & 32'hFFFF;
    endfunction

    function automatic int unsigned rol16(input int unsigned v, input int unsigned n);
        return ((v << n) | (v >> (16 - n))) & 32'hFFFF;
    endfunction

    task automatic model(input logic [31:0] blk, input logic [63:0] key, output logic [31:0] ct);
        int unsigned l [0:24];
        int unsigned kk, xx, yy;
        kk   = key[15:0];
        l[0] = key[31:16];
        l[1] = key[47:32];
        l[2] = key[63:48];
        xx   = blk[31:16];
        yy   = blk[15:0];
        for (int i = 0; i < 22; i++) begin
            mk[i]    = kk;
            xx       = ((ror16(xx, 7) + yy) & 32'hFFFF) ^ kk;
            yy       = rol16(yy, 2) ^ xx;
            l[i + 3] = ((kk + ror16(l[i], 7)) & 32'hFFFF) ^ i;
            kk       = rol16(kk, 2) ^ l[i + 3];
        end
        ct = {xx[15:0], yy[15:0]};
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one block; returns in the first RUN cycle (T+1).
    task automatic send(input logic [31:0] blk, input logic [63:0] key);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        chk("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b1;
        in_block = blk;
        in_key   = key;
        step();
        in_valid = 1'b0;
    endtask

    // Walk rounds 0..21 from T+1; optionally scramble the input port every cycle.
    task automatic run_rounds(input bit trace, input bit scramble);
        for (int r = 0; r < 22; r++) begin
            if (trace) begin
                chk($sformatf("debug_key_r%0d", r), debug_key, 64'(mk[r]));
                chk($sformatf("round_idx_r%0d", r), round_idx, 64'(r));
            end
            if (r == 0 || r == 21) begin
                chk("out_valid_in_run", out_valid, 1'b0);
                chk("in_ready_in_run", in_ready, 1'b0);
                chk("busy_in_run", busy, 1'b1);
            end
            if (scramble) begin
                in_valid = 1'($urandom_range(0, 1));
                in_block = $urandom();
                in_key   = {$urandom(), $urandom()};
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_left"}, left, 16'h0);
        chk({tag, "_right"}, right, 16'h0);
        chk({tag, "_round_idx"}, round_idx, 5'd0);
        chk({tag, "_debug_key"}, debug_key, 16'h0);
    endtask

    initial begin
        logic [31:0] ct;
        logic [31:0] pend_blk;
        logic [63:0] pend_key;
        logic        seen_valid;
        int sent;
        int got;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_block  = '0;
        in_key    = '0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Known answer with trace of round keys; out_ready high throughout.
        model(KAT_BLK, KAT_KEY, ct);
        chk("model_kat", ct, KAT_CT);
        chk("model_k0", 64'(mk[0]), 64'h0100);
        send(KAT_BLK, KAT_KEY);
        run_rounds(1'b1, 1'b0);
        chk("kat_out_valid", out_valid, 1'b1);
        chk("kat_left", left, KAT_CT[31:16]);
        chk("kat_right", right, KAT_CT[15:0]);
        chk("kat_round_idx_done", round_idx, 5'd0);
        step();
        chk("kat_idle_in_ready", in_ready, 1'b1);
        chk("kat_idle_out_valid", out_valid, 1'b0);
        chk("kat_idle_busy", busy, 1'b0);
        chk("kat_idle_left", left, KAT_CT[31:16]);

        // Back-pressure: hold result for 5 cycles with out_ready low.
        out_ready = 1'b0;
        send(KAT_BLK, KAT_KEY);
        run_rounds(1'b0, 1'b0);
        for (int c = 0; c < 6; c++) begin
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_left", left, KAT_CT[31:16]);
            chk("bp_right", right, KAT_CT[15:0]);
            if (c < 5) step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_in_ready", in_ready, 1'b1);
        chk("bp_release_out_valid", out_valid, 1'b0);

        // Reset in the middle of a run: everything clears and no result ever appears.
        send(KAT_BLK, KAT_KEY);
        for (int c = 0; c < 10; c++) step();
        chk("mid_round_idx", round_idx, 5'd10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("midreset");
        seen_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid) seen_valid = 1'b1;
            step();
        end
        chk("midreset_no_output", seen_valid, 1'b0);
        send(KAT_BLK, KAT_KEY);
        run_rounds(1'b0, 1'b0);
        chk("post_reset_left", left, KAT_CT[31:16]);
        chk("post_reset_right", right, KAT_CT[15:0]);
        step();

        // Inputs thrashed during RUN must not disturb the block or cause a second accept.
        send(KAT_BLK, KAT_KEY);
        run_rounds(1'b0, 1'b1);
        chk("ign_out_valid", out_valid, 1'b1);
        chk("ign_left", left, KAT_CT[31:16]);
        chk("ign_right", right, KAT_CT[15:0]);
        step();
        chk("ign_idle_busy", busy, 1'b0);
        step();
        chk("ign_no_second_accept", busy, 1'b0);

        // Back-to-back random traffic with random consumer stalls, scoreboarded in order.
        sent     = 0;
        got      = 0;
        pend_blk = $urandom();
        pend_key = {$urandom(), $urandom()};
        for (int cyc = 0; cyc < 6000 && got < 50; cyc++) begin
            in_valid  = (sent < 50) && ($urandom_range(0, 3) != 0);
            in_block  = pend_blk;
            in_key    = pend_key;
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) begin
                model(pend_blk, pend_key, ct);
                exp_q.push_back(ct);
                sent++;
                pend_blk = $urandom();
                pend_key = {$urandom(), $urandom()};
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("b2b_unexpected_output", 1'b1, 1'b0);
                end else begin
                    ct = exp_q.pop_front();
                    chk($sformatf("b2b_result_%0d", got), {left, right}, ct);
                end
                got++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("b2b_sent", sent, 50);
        chk("b2b_received", got, 50);
        chk("b2b_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
